// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//
// Avalon-MM slave driving NUM_DIGITS active-low seven-segment displays.
// Each digit shows either a hardware-decoded hex nibble or a raw segment
// pattern, can blink at BLINK_HZ, and all digits share a PWM brightness.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   avs_address    word address (0x0 CTRL, 0x1 DECODE_MASK, 0x2 BLINK_MASK,
//                  0x3 VALUE, 0x4+i RAW_i)
//   avs_read       read strobe (read latency 1)
//   avs_write      write strobe
//   avs_writedata  write data
//   avs_readdata   registered read data, holds between reads
//   hex_out        registered segment outputs, active-low, digit i at
//                  [7i+6:7i], bit order g..a
module hex_display_ctrl #(
  parameter int NUM_DIGITS  = 6,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BLINK_HZ    = 2,
  parameter int PWM_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BLINK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  // A divider of 1 still needs a 1-bit counter so the port widths stay legal.
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_DIV - 1);

  // Active-high g..a segment pattern for a hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Register file
  logic                         enable_q,     enable_d;
  logic [PWM_BITS-1:0]          duty_q,       duty_d;
  logic [NUM_DIGITS-1:0]        dec_mask_q,   dec_mask_d;
  logic [NUM_DIGITS-1:0]        blink_mask_q, blink_mask_d;
  logic [4*NUM_DIGITS-1:0]      value_q,      value_d;
  logic [NUM_DIGITS-1:0][6:0]   raw_q,        raw_d;

  // Free-running timebases
  logic [BCNT_W-1:0]            blink_cnt_q,  blink_cnt_d;
  logic                         blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0]          pwm_cnt_q,    pwm_cnt_d;

  // Bus and display outputs
  logic [31:0]                  readdata_q,   readdata_d;
  logic [7*NUM_DIGITS-1:0]      hex_q,        hex_d;

  logic [31:0]                  rd_data;
  logic                         pwm_on;
  logic [NUM_DIGITS-1:0][6:0]   seg_lit;
  logic [NUM_DIGITS-1:0]        blank;

  // Only some write-data bits are stored; the rest are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Register writes. Bits beyond what each register implements are dropped,
  // and addresses with no backing register are ignored.
  always_comb begin
    enable_d     = enable_q;
    duty_d       = duty_q;
    dec_mask_d   = dec_mask_q;
    blink_mask_d = blink_mask_q;
    value_d      = value_q;
    raw_d        = raw_q;
    if (avs_write) begin
      case (avs_address)
        4'h0: begin
          enable_d = avs_writedata[0];
          duty_d   = avs_writedata[4 +: PWM_BITS];
        end
        4'h1: dec_mask_d   = avs_writedata[NUM_DIGITS-1:0];
        4'h2: blink_mask_d = avs_writedata[NUM_DIGITS-1:0];
        4'h3: value_d      = avs_writedata[4*NUM_DIGITS-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(avs_address) == i + 4) raw_d[i] = avs_writedata[6:0];
          end
        end
      endcase
    end
  end

  // Read mux works from the current (pre-write) register values, so a
  // simultaneous read and write of one location returns the old contents.
  always_comb begin
    rd_data = '0;
    case (avs_address)
      4'h0: begin
        rd_data[0]             = enable_q;
        rd_data[4 +: PWM_BITS] = duty_q;
      end
      4'h1: rd_data[NUM_DIGITS-1:0]   = dec_mask_q;
      4'h2: rd_data[NUM_DIGITS-1:0]   = blink_mask_q;
      4'h3: rd_data[4*NUM_DIGITS-1:0] = value_q;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (int'(avs_address) == i + 4) rd_data[6:0] = raw_q[i];
        end
      end
    endcase
  end

  assign readdata_d = avs_read ? rd_data : readdata_q;

  // Blink prescaler: phase flips each time the counter wraps, giving equal
  // on and off halves of BLINK_DIV cycles. Register writes never touch it.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // PWM counter wraps naturally; all-ones duty is forced fully on so the top
  // setting really is 100% rather than (2^N-1)/2^N.
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_on    = (&duty_q) | (pwm_cnt_q < duty_q);

  always_comb begin
    seg_lit = '0;
    blank   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_lit[i] = dec_mask_q[i] ? hex_decode(value_q[4*i +: 4]) : raw_q[i];
      blank[i]   = ~enable_q | ~pwm_on | (blink_mask_q[i] & blink_phase_q);
    end
  end

  always_comb begin
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_d[7*i +: 7] = blank[i] ? 7'h7F : ~seg_lit[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b1;
      duty_q        <= '1;
      dec_mask_q    <= '1;
      blink_mask_q  <= '0;
      value_q       <= '0;
      raw_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      readdata_q    <= '0;
      hex_q         <= '1;
    end else begin
      enable_q      <= enable_d;
      duty_q        <= duty_d;
      dec_mask_q    <= dec_mask_d;
      blink_mask_q  <= blink_mask_d;
      value_q       <= value_d;
      raw_q         <= raw_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      readdata_q    <= readdata_d;
      hex_q         <= hex_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign hex_out      = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int ND = 6;

  logic          clk;
  logic          reset_n;
  logic [3:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic [7*ND-1:0] hex_out;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  string       nm_q[$];

  typedef struct {
    logic [3:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     exp_rd;
    logic [7*ND-1:0] exp_hex;
  } vec_t;

  vec_t vecs[13];

  hex_display_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_FREQ_HZ (40),
    .BLINK_HZ    (2),
    .PWM_BITS    (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .hex_out       (hex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic pop_compare();
    logic [31:0] e;
    string       nm;
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    check(nm, avs_readdata, e);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] e, input string nm);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    tick();
    avs_read = 1'b0;
    pop_compare();
  endtask

  task automatic do_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] e,
                       input string nm);
    avs_address   = a;
    avs_writedata = d;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    tick();
    avs_read  = 1'b0;
    avs_write = 1'b0;
    pop_compare();
  endtask

  task automatic count_lit(input int ncyc, output int lit);
    lit = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (hex_out != '1) lit++;
      tick();
    end
  endtask

  initial begin
    logic [7*ND-1:0] steady;
    logic [6:0]      snap, lvl0, other, expd;
    logic [7*ND-8:0] upper;
    int              waitc;
    bit              found;
    int              lit;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{4'h3, 32'h0000_A5F3, 32'h0000_A5F3, {7'h40, 7'h40, 7'h08, 7'h12, 7'h0E, 7'h30}};
    vecs[1]  = '{4'h3, 32'h0012_3456, 32'h0012_3456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
    vecs[2]  = '{4'h3, 32'h0078_9ABC, 32'h0078_9ABC, {7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46}};
    vecs[3]  = '{4'h3, 32'h12FE_DCBA, 32'h00FE_DCBA, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
    vecs[4]  = '{4'h1, 32'h0000_003E, 32'h0000_003E, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h7F}};
    vecs[5]  = '{4'h4, 32'h0000_0049, 32'h0000_0049, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h36}};
    vecs[6]  = '{4'h9, 32'hFFFF_FFC0, 32'h0000_0040, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h36}};
    vecs[7]  = '{4'hB, 32'hFFFF_FFFF, 32'h0000_0000, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h36}};
    vecs[8]  = '{4'hF, 32'hFFFF_FFFF, 32'h0000_0000, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h36}};
    vecs[9]  = '{4'hA, 32'h0000_007F, 32'h0000_0000, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h36}};
    vecs[10] = '{4'h1, 32'hFFFF_FF00, 32'h0000_0000, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h36}};
    vecs[11] = '{4'h1, 32'h0000_003F, 32'h0000_003F, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
    vecs[12] = '{4'h0, 32'hFFFF_FFF1, 32'h0000_00F1, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};

    reset_n       = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;

    // Reset asserted mid-cycle must blank the display at once
    #3 reset_n = 1'b0;
    #1 check("reset_hex_async", hex_out, {7*ND{1'b1}});
    repeat (2) @(posedge clk);
    #1;
    check("reset_readdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    tick();
    check("reset_release_hex", hex_out, {ND{7'h40}});
    do_read(4'h0, 32'h0000_00F1, "reset_ctrl");
    do_read(4'h1, 32'h0000_003F, "reset_decode_mask");
    do_read(4'h2, 32'h0000_0000, "reset_blink_mask");

    // Register writes, readback and decoded/raw output
    for (int i = 0; i < 13; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      do_read(vecs[i].addr, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
      check($sformatf("vec%0d_hex", i), hex_out, vecs[i].exp_hex);
    end
    steady = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};

    // Blink digit 0 only: runs of 10 cycles on and 10 off
    do_write(4'h2, 32'h0000_0001);
    tick();
    snap  = hex_out[6:0];
    found = 1'b0;
    waitc = 0;
    while (!found && waitc < 25) begin
      tick();
      waitc++;
      if (hex_out[6:0] != snap) found = 1'b1;
    end
    check("blink_edge_seen", 64'(found), 64'd1);
    lvl0  = hex_out[6:0];
    check("blink_level_valid", 64'((lvl0 == 7'h7F) || (lvl0 == 7'h08)), 64'd1);
    other = (lvl0 == 7'h7F) ? 7'h08 : 7'h7F;
    upper = steady[7*ND-1:7];
    for (int k = 0; k < 40; k++) begin
      expd = (((k / 10) % 2) == 0) ? lvl0 : other;
      check($sformatf("blink_d0_c%0d", k), hex_out[6:0], expd);
      check($sformatf("blink_others_c%0d", k), hex_out[7*ND-1:7], upper);
      tick();
    end
    do_write(4'h2, 32'h0000_0000);
    tick();
    check("blink_off_hex", hex_out, steady);

    // Simultaneous read and write returns the old value
    do_rw(4'h2, 32'h0000_0015, 32'h0000_0000, "rw_same_cycle");
    do_read(4'h2, 32'h0000_0015, "rw_followup");
    do_write(4'h2, 32'h0000_0000);

    // Brightness: lit cycles over two full PWM periods
    do_write(4'h0, 32'h0000_0031);
    do_read(4'h0, 32'h0000_0031, "ctrl_duty3_rd");
    count_lit(32, lit);
    check("pwm_duty3", lit, 6);
    do_write(4'h0, 32'hFFFF_FFE1);
    do_read(4'h0, 32'h0000_00E1, "ctrl_duty14_rd");
    count_lit(32, lit);
    check("pwm_duty14", lit, 28);
    do_write(4'h0, 32'h0000_0001);
    tick();
    count_lit(32, lit);
    check("pwm_duty0", lit, 0);
    do_write(4'h0, 32'h0000_00F0);
    tick();
    count_lit(32, lit);
    check("disable_full_duty", lit, 0);
    do_write(4'h0, 32'h0000_0000);
    tick();
    count_lit(32, lit);
    check("disable_duty0", lit, 0);
    do_write(4'h0, 32'h0000_00F1);
    tick();
    count_lit(32, lit);
    check("pwm_full", lit, 32);
    check("pwm_full_hex", hex_out, steady);

    // Second reset in the middle of operation
    #2 reset_n = 1'b0;
    #1;
    check("reset2_hex_async", hex_out, {7*ND{1'b1}});
    check("reset2_readdata", avs_readdata, 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();
    check("reset2_release_hex", hex_out, {ND{7'h40}});
    do_read(4'h3, 32'h0000_0000, "reset2_value");
    do_read(4'h4, 32'h0000_0000, "reset2_raw0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised Avalon-MM slave that drives NUM_DIGITS active-low seven-segment displays from a small register file, replacing one-PIO-per-digit hex outputs. Per digit: hardware hex decode or raw segment drive, plus hardware blink. A global PWM brightness control applies to all digits. Sits on the Nios II data bus next to the LED/switch PIOs; its output bus goes straight to the HEX pins.

## Interface
- NUM_DIGITS, 6, number of digits driven; legal 1..8.
- CLK_FREQ_HZ, 50000000, clk frequency in Hz.
- BLINK_HZ, 2, full blink cycles per second; BLINK_DIV = CLK_FREQ_HZ/(2*BLINK_HZ), must be ≥1.
- PWM_BITS, 4, brightness resolution; legal 1..8.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  4  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, read latency 1.
- hex_out  out  7*NUM_DIGITS  segments, active-low; digit i occupies [7i+6:7i], bit order g..a (a = LSB).

## Operation
- Registers (word addresses):
  - 0x0 CTRL: bit0 ENABLE, bits[4+PWM_BITS-1:4] DUTY. Reset: ENABLE=1, DUTY=all ones.
  - 0x1 DECODE_MASK: bit i=1 selects hex decode for digit i, 0 selects raw. Reset: all ones.
  - 0x2 BLINK_MASK: bit i=1 makes digit i blink. Reset: 0.
  - 0x3 VALUE: nibble i (bits[4i+3:4i]) is the hex value for digit i. Reset: 0.
  - 0x4+i RAW_i (i<NUM_DIGITS): bits[6:0] are active-high raw segments g..a. Reset: 0.
- Only implemented bits are stored. Unimplemented bits, unmapped addresses, and RAW_i with i≥NUM_DIGITS read 0. Writes to those locations are ignored.
- Decode (active-high g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Blink prescaler:
  - Free-running counter 0..BLINK_DIV-1.
  - On wrap, blink_phase toggles. Reset phase is 0.
  - The counter is not cleared by register writes.
- PWM:
  - Free-running PWM_BITS counter pwm_cnt, increments every clk, wraps naturally.
  - pwm_on = (DUTY == all ones) | (pwm_cnt < DUTY). DUTY=0 means always off.
- Per-digit lit pattern seg_i = DECODE_MASK[i] ? decode(nibble i) : RAW_i[6:0].
- Digit i is blanked when any of the following holds:
  - ENABLE=0
  - !pwm_on
  - BLINK_MASK[i] & blink_phase
- hex_out[7i+6:7i] = blanked ? 7'h7F : ~seg_i. This value is registered.
- Reads: avs_readdata is registered from avs_address when avs_read=1. It holds its previous value otherwise.
- Write and read asserted in the same cycle: the write is performed, and avs_readdata returns the pre-write value.

## Timing
- Reset (async assert, sync release by the system): registers take their reset values, counters go to 0, blink_phase=0, avs_readdata=0, hex_out=all ones (all segments off).
- A write at edge N updates the register at edge N. The visible effect on hex_out appears at edge N+1 (1-cycle output latency).
- A read at edge N gives avs_readdata valid after edge N; the master samples it at edge N+1.
- blink_phase toggles every BLINK_DIV cycles, so a blinking digit is on for BLINK_DIV cycles and off for BLINK_DIV cycles. hex_out follows the toggle one cycle later.
- PWM period is 2^PWM_BITS cycles. The on-cycles per period equal DUTY, or the full period when DUTY is all ones.
- No wait states. No internal state machine beyond the counters. A reset mid-blink or mid-PWM restarts both counters from 0.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> hex_out=all ones immediately. One cycle after release -> every digit = 7'h40 ("0"), and read of 0x0 returns 0x000000F1 (PWM_BITS=4).
- Decode: write VALUE=0x00A5F3 -> one cycle later digits 0..5 = ~{4F,71,6D,77,3F,3F} = 30,0E,12,08,40,40. Read 0x3 returns 0x00A5F3.
- Raw mode: write DECODE_MASK=0x3E, RAW_0=0x49 -> digit0 = 7'h36, other digits unchanged. Write to address 0xB (NUM_DIGITS=6) -> its read returns 0 and no output changes.
- Blink (CLK_FREQ_HZ=40, BLINK_HZ=2): BLINK_MASK=0x01 -> digit0 toggles between 7'h7F and its pattern every 10 cycles, while the other digits stay steady.
- Brightness: CTRL=0x31 (DUTY=3) -> digits are lit for exactly 3 of every 16 cycles. CTRL=0x01 -> always blank. CTRL=0x00 with DUTY ignored -> always blank.
- Simultaneous read+write to 0x2 (old value 0x00, new value 0x15) -> readdata=0x00. A subsequent read returns 0x15.
